// File: rtl/glip_upscale_n.sv
// Packs RATIO consecutive IN_SIZE-bit words (first word most significant) into one
// registered OUT_SIZE-bit word, with flush-to-partial-word support and a lane count.
module glip_upscale_n #(
    parameter int IN_SIZE  = 8,
    parameter int RATIO    = 2,
    parameter int OUT_SIZE = IN_SIZE * RATIO,
    parameter int LANE_W   = $clog2(RATIO + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_SIZE-1:0]  in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    output logic [OUT_SIZE-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANE_W-1:0]   out_lanes
);

    if (OUT_SIZE != IN_SIZE * RATIO) begin : g_bad_out_size
        $fatal(1, "glip_upscale_n: OUT_SIZE must equal IN_SIZE*RATIO");
    end
    if (RATIO < 1 || RATIO > 16) begin : g_bad_ratio
        $fatal(1, "glip_upscale_n: RATIO must be in 1..16");
    end

    logic                ofree;
    logic                acc_in;
    logic                cnt_lt;      // cnt < RATIO-1: room left in acc
    logic                cnt_zero;
    logic                full_load;
    logic                part_emit;
    logic                flush_act;
    logic                flush_pend_q;
    logic                flush_pend_d;
    logic [OUT_SIZE-1:0] full_word;
    logic [OUT_SIZE-1:0] part_word;
    logic [LANE_W-1:0]   part_lanes;

    assign ofree     = !out_valid || out_ready;
    assign in_ready  = cnt_lt || ofree;
    assign acc_in    = in_valid && in_ready;
    assign flush_act = flush || flush_pend_q;
    assign full_load = acc_in && !cnt_lt;
    assign part_emit = flush_act && !cnt_zero && ofree && !full_load;

    if (RATIO > 1) begin : g_acc
        localparam int CNT_W = $clog2(RATIO);

        logic [CNT_W-1:0]                 cnt_q;
        logic [CNT_W-1:0]                 cnt_d;
        logic [RATIO-2:0][IN_SIZE-1:0]    acc_q;

        assign cnt_lt     = cnt_q < CNT_W'(RATIO - 1);
        assign cnt_zero   = cnt_q == '0;
        assign part_lanes = LANE_W'(cnt_q);

        always_comb begin
            cnt_d = cnt_q;
            if (full_load) begin
                cnt_d = '0;
            end else if (part_emit) begin
                // A word accepted alongside a partial emit starts the next word.
                cnt_d = acc_in ? CNT_W'(1) : '0;
            end else if (acc_in) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        always_ff @(posedge clk) begin
            for (int k = 0; k < RATIO - 1; k++) begin
                if (acc_in && !full_load &&
                    (part_emit ? (k == 0) : (cnt_q == CNT_W'(k)))) begin
                    acc_q[k] <= in_data;
                end
            end
        end

        always_comb begin
            full_word = '0;
            part_word = '0;
            full_word[IN_SIZE-1:0] = in_data;
            for (int k = 0; k < RATIO - 1; k++) begin
                full_word[OUT_SIZE-1-k*IN_SIZE -: IN_SIZE] = acc_q[k];
                if (CNT_W'(k) < cnt_q) begin
                    part_word[OUT_SIZE-1-k*IN_SIZE -: IN_SIZE] = acc_q[k];
                end
            end
        end
    end else begin : g_pass
        assign cnt_lt     = 1'b0;
        assign cnt_zero   = 1'b1;
        assign full_word  = in_data;
        assign part_word  = '0;
        assign part_lanes = '0;
    end

    // Pending flush survives only while there is partial data it could not yet emit.
    assign flush_pend_d = flush_act && !part_emit && !cnt_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pend_q <= 1'b0;
        end else begin
            flush_pend_q <= flush_pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lanes <= '0;
        end else if (full_load) begin
            out_valid <= 1'b1;
            out_data  <= full_word;
            out_lanes <= LANE_W'(RATIO);
        end else if (part_emit) begin
            out_valid <= 1'b1;
            out_data  <= part_word;
            out_lanes <= part_lanes;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_glip_upscale_n.sv
// Scoreboard bench for glip_upscale_n (IN_SIZE=8, RATIO=4): directed scenarios then
// randomized traffic against a queue-based word-packing model.
module tb_glip_upscale_n;

    localparam int R  = 4;
    localparam int W  = 8;
    localparam int OW = W * R;
    localparam int LW = $clog2(R + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          flush = 1'b0;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [LW-1:0] out_lanes;

    glip_upscale_n #(
        .IN_SIZE(W),
        .RATIO  (R)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_lanes(out_lanes)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] d;
        logic [LW-1:0] l;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];
    logic [W-1:0] held[$];
    bit         m_ov = 1'b0;
    bit         m_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check handshake outputs, advance the model.
    task automatic cyc(input bit v, input logic [W-1:0] d, input bit f, input bit r);
        bit            ofree, ir, acc, fl, full, part;
        int            n;
        logic [OW-1:0] w;
        @(negedge clk);
        in_valid = v; in_data = d; flush = f; out_ready = r;
        #1;
        ofree = !m_ov || r;
        ir    = (held.size() < R - 1) || ofree;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("in_ready", 32'(in_ready), 32'(ir));
        acc  = v && ir;
        fl   = f || m_pend;
        n    = held.size();
        full = acc && (n == R - 1);
        part = !full && fl && (n > 0) && ofree;
        if (full || part) begin
            w = '0;
            for (int i = 0; i < n; i++) w[OW-1-W*i -: W] = held[i];
            if (full) w[W-1:0] = d;
            sb.push_back('{d: w, l: (full ? LW'(R) : LW'(n))});
            held.delete();
        end
        if (acc && !full) held.push_back(d);
        m_pend = fl && !part && (n > 0);
        m_ov   = (full || part) ? 1'b1 : (m_ov && !r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_lanes", 32'(out_lanes), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        held.delete();
        sb.delete();
        m_ov   = 1'b0;
        m_pend = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [OW-1:0] d, input int l);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_data"}, out_data, d);
        chk({name, "_lanes"}, 32'(out_lanes), 32'(l));
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got data 0x%0h, expected no word", out_data);
                end else begin
                    e = sb.pop_front();
                    chk("sb_out_data", out_data, e.d);
                    chk("sb_out_lanes", 32'(out_lanes), 32'(e.l));
                end
            end
        end
    end

    initial begin
        do_reset();

        // Continuous full words
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, W'(8'h11 * i), 1'b0, 1'b1);
            if (i == 5) expect_out("full1", 32'h11223344, 4);
        end
        cyc(1'b0, '0, 1'b0, 1'b1);
        expect_out("full2", 32'h55667788, 4);

        // Flush of a two-lane partial word
        cyc(1'b1, 8'hAA, 1'b0, 1'b1);
        cyc(1'b1, 8'hBB, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        expect_out("flush2", 32'hAABB0000, 2);
        for (int i = 1; i <= 4; i++) cyc(1'b1, W'(i), 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        expect_out("after_flush", 32'h01020304, 4);

        // Back-pressure: output held, acc fills to three lanes, then input stalls
        for (int i = 1; i <= 7; i++) cyc(1'b1, W'(8'h10 * i), 1'b0, 1'b0);
        cyc(1'b1, 8'h80, 1'b0, 1'b0);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        expect_out("stall_hold", 32'h10203040, 4);
        cyc(1'b1, 8'h80, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1);

        // Flush with nothing held, then flush on the completing word
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("flush_empty_no_out", 32'(out_valid), 32'd0);
        cyc(1'b1, 8'hA0, 1'b0, 1'b1);
        cyc(1'b1, 8'hB0, 1'b0, 1'b1);
        cyc(1'b1, 8'hC0, 1'b0, 1'b1);
        cyc(1'b1, 8'hD0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        expect_out("flush_full", 32'hA0B0C0D0, 4);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("no_extra_partial", 32'(out_valid), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Flush coinciding with an accepted word
        cyc(1'b1, 8'hAA, 1'b0, 1'b1);
        cyc(1'b1, 8'hBB, 1'b0, 1'b1);
        cyc(1'b1, 8'h33, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        expect_out("flush_accept", 32'hAABB0000, 2);
        cyc(1'b1, 8'h44, 1'b0, 1'b1);
        cyc(1'b1, 8'h55, 1'b0, 1'b1);
        cyc(1'b1, 8'h66, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        expect_out("carry_lane0", 32'h33445566, 4);

        // Reset with a pending output word and two lanes held
        for (int i = 1; i <= 6; i++) cyc(1'b1, W'(8'h20 + i), 1'b0, 1'b0);
        do_reset();
        for (int i = 1; i <= 4; i++) cyc(1'b1, W'(8'hE0 + i), 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        expect_out("post_reset", 32'hE1E2E3E4, 4);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cyc(($urandom_range(0, 9) < 7), W'($urandom), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) < 6));
            end
        end

        // Drain everything still held
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b1);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/glip_upscale_n.md
Name: glip_upscale_n

Overview:
- Generalised FIFO-interface upscaler: packs RATIO consecutive IN_SIZE-bit input words into one OUT_SIZE-bit output word.
- Adds a registered output stage, a flush mechanism that emits a zero-padded partial word, and a lane-count side channel.
- Sits between narrow GLIP transport FIFOs (e.g. 8/16-bit link logic) and wider user-side FIFOs.

Parameters:
- IN_SIZE, 8, input word width in bits.
- RATIO, 2, number of input words per output word; legal range 1..16.
- OUT_SIZE, IN_SIZE*RATIO, output width in bits. Any other value triggers an elaboration-time fatal assertion.
- LANE_W, $clog2(RATIO+1), width of out_lanes. Derived; not to be overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  IN_SIZE  input word.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept in_data this cycle.
- flush  in  1  single-cycle pulse: emit any partially assembled word.
- out_data  out  OUT_SIZE  assembled output word (registered).
- out_valid  out  1  out_data valid (registered).
- out_ready  in  1  downstream accepts out_data.
- out_lanes  out  LANE_W  number of valid lanes in out_data, 1..RATIO (registered).

Behaviour:
- State:
  - acc: RATIO-1 lanes of IN_SIZE.
  - cnt: 0..RATIO-1, lanes held in acc.
  - flush_pend: 1 bit.
  - Output register: out_data, out_valid, out_lanes.
- Lane order:
  - The first received word is the most significant.
  - Lane k occupies out_data[OUT_SIZE-1-k*IN_SIZE -: IN_SIZE].
- Accept condition: acc_in = in_valid & in_ready.
- Output register free condition: ofree = !out_valid | out_ready.
- in_ready = (cnt < RATIO-1) | ofree. This is combinational from out_valid and out_ready only, never from in_valid.
- acc_in with cnt < RATIO-1: acc lane cnt <= in_data; cnt <= cnt+1.
- acc_in with cnt == RATIO-1:
  - Output register loads {acc lanes 0..RATIO-2, in_data}; out_lanes <= RATIO; out_valid <= 1; cnt <= 0.
  - Latency: out_valid is asserted the cycle after the last input word is accepted.
- Output drain: out_valid & out_ready with no new load in the same cycle -> out_valid <= 0. A load and a drain in the same cycle are allowed and give full throughput: one output word every RATIO cycles with no bubbles.
- Flush:
  - flush pulse sets flush_pend.
  - Partial emit fires when flush_pend & cnt > 0 & ofree & no full-word load this cycle.
  - Partial emit: output register loads filled lanes 0..cnt-1 with lanes cnt..RATIO-1 forced to zero; out_lanes <= cnt; out_valid <= 1; cnt <= 0; flush_pend <= 0.
  - flush_pend with cnt == 0 clears the next cycle; no word is emitted and no empty word is ever produced.
- Flush simultaneous events:
  - Input accepted in the same cycle as the partial-emit condition: the partial emit takes priority and the accepted word is stored as lane 0 of the next word (cnt <= 1).
  - Input accepted in a cycle that completes a full word: the full word is emitted. flush_pend then sees cnt == 0 and clears.
  - flush pulse while flush_pend is already set: no additional effect.
- Flush blocked by output: with ofree == 0, flush_pend holds and inputs keep filling acc up to cnt == RATIO-1.
- RATIO == 1:
  - Block is a single registered pipeline stage; acc absent; cnt fixed at 0.
  - Every output has out_lanes = 1; flush has no effect.
- Reset values: out_valid 0, out_data 0, out_lanes 0, cnt 0, flush_pend 0. in_ready is 1 in the first cycle after reset.
- Reset mid-operation: partial contents of acc and any pending output word are discarded silently.
- Stability: out_data and out_lanes hold stable while out_valid & !out_ready.

Test Plan:
- IN_SIZE=8, RATIO=4, continuous inputs 0x11,0x22,0x33,0x44,0x55..0x88, out_ready=1 -> out_data 0x11223344 then 0x55667788, each with out_lanes=4, one cycle after the 4th word; in_ready never drops.
- RATIO=4, inputs 0xAA,0xBB, then flush pulse -> out_data 0xAABB0000 with out_lanes=2 the cycle after flush; the next inputs 0x01..0x04 give 0x01020304 with out_lanes=4.
- RATIO=4, out_ready=0 while 7 words are sent -> first word is held stable; in_ready=0 with cnt=3; raise out_ready -> 4th stored word and following inputs resume with no data lost or duplicated.
- RATIO=3, flush with cnt=0 -> no output; flush in the same cycle as 0xC0 accepted at cnt=2 -> a single full word 0xA0B0C0 (given prior 0xA0,0xB0), no extra partial word.
- RATIO=4, flush at cnt=2 in the same cycle as acceptance of 0x33 -> partial word 0xAABB0000 with out_lanes=2 is emitted; 0x33 becomes lane 0 of the next word.
- Assert rst with cnt=2 and out_valid=1 -> next cycle out_valid=0, out_lanes=0, in_ready=1; the next 4 inputs form a clean full word.
- RATIO=1, IN_SIZE=16, inputs 0xBEEF,0xCAFE -> each appears on out_data one cycle later with out_lanes=1.
